// File: rtl/dma_arb_wr_pkg.sv
// Shared constants for the two-channel DMA-to-AXI-Lite write arbiter.
// FSM encoding, counter width and response codes live here so all users agree.
package dma_arb_wr_pkg;

    localparam int DMA_ARB_WR_FSM_WIDTH = 2;
    localparam int AXIL_CNT_WIDTH       = 8;

    typedef enum logic [DMA_ARB_WR_FSM_WIDTH-1:0] {
        FSM_DMA_ARB_WR_IDLE     = 2'd0,
        FSM_DMA_ARB_WR_CH0      = 2'd1,
        FSM_DMA_ARB_WR_CH1      = 2'd2,
        FSM_DMA_ARB_WR_ABORTING = 2'd3
    } dma_arb_wr_state_e;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_ABORT   = 2'b10;
    localparam logic [1:0] RESP_TIMEOUT = 2'b11;

    // Saturating increment: the grant timer must never wrap back below TIMEOUT-1.
    function automatic logic [AXIL_CNT_WIDTH-1:0] cnt_sat_inc(input logic [AXIL_CNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/dma_arb_wr.sv
// Round-robin arbiter granting one single-beat AXI-Lite write at a time to
// DMA channel 0 or 1, with abort, response timeout and B-drain after abort.
module dma_arb_wr
    import dma_arb_wr_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_abort,

    input  logic                    i_ch0_req,
    input  logic [ADDR_WIDTH-1:0]   i_ch0_addr,
    input  logic [DATA_WIDTH-1:0]   i_ch0_data,
    input  logic [DATA_WIDTH/8-1:0] i_ch0_strb,
    output logic                    o_ch0_done,
    output logic [1:0]              o_ch0_resp,

    input  logic                    i_ch1_req,
    input  logic [ADDR_WIDTH-1:0]   i_ch1_addr,
    input  logic [DATA_WIDTH-1:0]   i_ch1_data,
    input  logic [DATA_WIDTH/8-1:0] i_ch1_strb,
    output logic                    o_ch1_done,
    output logic [1:0]              o_ch1_resp,

    output logic                    o_awvalid,
    input  logic                    i_awready,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    output logic                    o_wvalid,
    input  logic                    i_wready,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH/8-1:0] o_wstrb,
    input  logic                    i_bvalid,
    output logic                    o_bready,
    input  logic [1:0]              i_bresp,

    output logic                    o_busy
);

    localparam logic [AXIL_CNT_WIDTH-1:0] TIMEOUT_LAST = AXIL_CNT_WIDTH'(TIMEOUT - 1);

    dma_arb_wr_state_e         state_q, state_d;
    logic                      aw_pend_q, aw_pend_d;
    logic                      w_pend_q, w_pend_d;
    logic                      last_ch1_q, last_ch1_d;
    logic [AXIL_CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [DATA_WIDTH/8-1:0]   strb_q;

    logic                      load;
    logic                      load_ch1;
    logic                      in_xfer;
    logic                      in_chan;
    logic                      b_hs;
    logic                      done;
    logic [1:0]                resp;

    assign in_chan = (state_q == FSM_DMA_ARB_WR_CH0) || (state_q == FSM_DMA_ARB_WR_CH1);
    assign in_xfer = in_chan || (state_q == FSM_DMA_ARB_WR_ABORTING);

    assign o_awvalid = aw_pend_q;
    assign o_wvalid  = w_pend_q;
    assign o_bready  = in_xfer && !aw_pend_q && !w_pend_q;
    assign b_hs      = o_bready && i_bvalid;

    assign o_awaddr  = addr_q;
    assign o_wdata   = data_q;
    assign o_wstrb   = strb_q;
    assign o_busy    = (state_q != FSM_DMA_ARB_WR_IDLE);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        aw_pend_d  = aw_pend_q && !i_awready;
        w_pend_d   = w_pend_q && !i_wready;
        last_ch1_d = last_ch1_q;
        cnt_d      = cnt_q;
        load       = 1'b0;
        load_ch1   = 1'b0;
        done       = 1'b0;
        resp       = RESP_OKAY;

        case (state_q)
            FSM_DMA_ARB_WR_IDLE: begin
                // On a tie the channel not served last wins.
                if (i_ch0_req && (!i_ch1_req || last_ch1_q)) begin
                    state_d = FSM_DMA_ARB_WR_CH0;
                    load    = 1'b1;
                end else if (i_ch1_req) begin
                    state_d  = FSM_DMA_ARB_WR_CH1;
                    load     = 1'b1;
                    load_ch1 = 1'b1;
                end
                if (load) begin
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                    cnt_d     = '0;
                end
            end

            FSM_DMA_ARB_WR_CH0, FSM_DMA_ARB_WR_CH1: begin
                cnt_d = cnt_sat_inc(cnt_q);
                if (b_hs) begin
                    done    = 1'b1;
                    resp    = i_bresp;
                    state_d = FSM_DMA_ARB_WR_IDLE;
                end else if (i_abort || (cnt_q == TIMEOUT_LAST)) begin
                    done    = 1'b1;
                    resp    = i_abort ? RESP_ABORT : RESP_TIMEOUT;
                    state_d = FSM_DMA_ARB_WR_ABORTING;
                end
                if (done) begin
                    last_ch1_d = (state_q == FSM_DMA_ARB_WR_CH1);
                end
            end

            FSM_DMA_ARB_WR_ABORTING: begin
                // Outstanding valids finish on their own; the drained B is dropped.
                if (b_hs) begin
                    state_d = FSM_DMA_ARB_WR_IDLE;
                end
            end

            default: begin
                state_d = FSM_DMA_ARB_WR_IDLE;
            end
        endcase
    end

    assign o_ch0_done = done && (state_q == FSM_DMA_ARB_WR_CH0);
    assign o_ch1_done = done && (state_q == FSM_DMA_ARB_WR_CH1);
    assign o_ch0_resp = o_ch0_done ? resp : RESP_OKAY;
    assign o_ch1_resp = o_ch1_done ? resp : RESP_OKAY;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= FSM_DMA_ARB_WR_IDLE;
            aw_pend_q  <= 1'b0;
            w_pend_q   <= 1'b0;
            last_ch1_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            aw_pend_q  <= aw_pend_d;
            w_pend_q   <= w_pend_d;
            last_ch1_q <= last_ch1_d;
            cnt_q      <= cnt_d;
        end
    end

    // NOTE: the request payload needs no reset; it is only observed while a valid is high.
    always_ff @(posedge i_clk) begin
        if (load) begin
            addr_q <= load_ch1 ? i_ch1_addr : i_ch0_addr;
            data_q <= load_ch1 ? i_ch1_data : i_ch0_data;
            strb_q <= load_ch1 ? i_ch1_strb : i_ch0_strb;
        end
    end

endmodule
